// File: rtl/serial_add32_ctrl_if.sv
// Handshake and external-adder signals for serial_add32_ctrl.
// The slave modport is the controller's view; master is the environment's view.
interface serial_add32_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic [7:0]  adder_a;
  logic [7:0]  adder_b;
  logic [7:0]  adder_sum;
  logic        adder_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_a,
    input  in_b,
    input  in_cin,
    output adder_a,
    output adder_b,
    input  adder_sum,
    input  adder_cout,
    output out_valid,
    input  out_ready,
    output out_sum,
    output out_cout
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_a,
    output in_b,
    output in_cin,
    input  adder_a,
    input  adder_b,
    output adder_sum,
    output adder_cout,
    input  out_valid,
    output out_ready,
    input  out_sum,
    input  out_cout
  );
endinterface

// File: rtl/serial_add32_ctrl.sv
// Byte-serial 32-bit adder controller driving an external 8-bit adder that has no
// carry input; the carry is folded in locally, one byte per cycle, LSB first.
module serial_add32_ctrl (
  input logic                clk,
  input logic                rst_n,
  serial_add32_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [1:0]  idx_q;
  logic        carry_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] sum_q;
  logic        cout_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [7:0]  adder_a_q;
  logic [7:0]  adder_b_q;

  logic [7:0]  byte_d;
  logic        carry_d;
  logic [1:0]  idx_inc;

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] r;
    unique case (i)
      2'd0:    r = w[7:0];
      2'd1:    r = w[15:8];
      2'd2:    r = w[23:16];
      default: r = w[31:24];
    endcase
    return r;
  endfunction

  // Adding the carry can only ripple out of the byte when the adder produced 8'hFF.
  always_comb begin
    byte_d  = bus.adder_sum + {7'b0, carry_q};
    carry_d = bus.adder_cout | ((bus.adder_sum == 8'hFF) & carry_q);
    idx_inc = idx_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= 2'd0;
      carry_q     <= 1'b0;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      sum_q       <= 32'h0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      adder_a_q   <= 8'h00;
      adder_b_q   <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q        <= bus.in_a;
            b_q        <= bus.in_b;
            carry_q    <= bus.in_cin;
            idx_q      <= 2'd0;
            state_q    <= StRun;
            in_ready_q <= 1'b0;
            adder_a_q  <= bus.in_a[7:0];
            adder_b_q  <= bus.in_b[7:0];
          end
        end
        StRun: begin
          sum_q[{idx_q, 3'b000} +: 8] <= byte_d;
          carry_q <= carry_d;
          idx_q   <= idx_inc;
          if (idx_q == 2'd3) begin
            cout_q      <= carry_d;
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            adder_a_q   <= 8'h00;
            adder_b_q   <= 8'h00;
          end else begin
            adder_a_q <= sel_byte(a_q, idx_inc);
            adder_b_q <= sel_byte(b_q, idx_inc);
          end
        end
        StDone: begin
          // No accept on this edge: in_ready only rises once back in idle.
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          adder_a_q   <= 8'h00;
          adder_b_q   <= 8'h00;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.adder_a   = adder_a_q;
  assign bus.adder_b   = adder_b_q;

endmodule
